// File: rtl/input_pipeline_unit_pkg.sv
// Shared definitions for the text-normalising input pipeline.
package input_pipeline_unit_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/byte_normalize.sv
// Single-byte normaliser: upper case folds to lower case, lower case and NUL pass
// through, anything else becomes a space.
module byte_normalize
    import input_pipeline_unit_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Classify the byte and pick its replacement.
    always_comb begin
        data_o = ASCII_SPACE;
        if (data_i >= 8'h41 && data_i <= 8'h5A) begin
            data_o = data_i + CASE_OFFSET;
        end else if ((data_i >= 8'h61 && data_i <= 8'h7A) || data_i == 8'h00) begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/sram_1R1W.sv
// 1-read / 1-write synchronous SRAM with registered read; read-during-write
// to the same address returns the old contents.
module sram_1R1W #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clock,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [DATA_W-1:0] WriteBus,
    input  logic [ADDR_W-1:0] ReadAddress,
    output logic [DATA_W-1:0] ReadBus
);

    logic [DATA_W-1:0] Register [0:(2**ADDR_W)-1];

    // Write port and registered read port share the rising edge.
    always_ff @(posedge clock) begin
        if (WE) begin
            Register[WriteAddress] <= WriteBus;
        end
        ReadBus <= Register[ReadAddress];
    end

endmodule

// File: rtl/input_pipeline_unit.sv
// Streams words from m1, normalises every byte and writes each result to the
// same address in m2, stopping after an all-zero word or the last address.
module input_pipeline_unit #(
    parameter int unsigned ADDR_W = input_pipeline_unit_pkg::ADDR_W,
    parameter int unsigned DATA_W = input_pipeline_unit_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] m1ReadAddr,
    input  logic [DATA_W-1:0] m1ReadVal,
    output logic [ADDR_W-1:0] m2ReadAddr,
    input  logic [DATA_W-1:0] m2ReadVal,
    output logic [ADDR_W-1:0] m2WriteAddr,
    output logic [DATA_W-1:0] m2WriteVal,
    output logic              m2WE,
    output logic              done
);

    import input_pipeline_unit_pkg::*;

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              halt_q, halt_d;   // no further reads may be issued
    logic              v1_q, v1_d;
    logic [ADDR_W-1:0] a1_q, a1_d;
    logic              last_q, last_d;   // write register holds the terminating word
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wval_q, wval_d;
    logic              we_q, we_d;

    logic [DATA_W-1:0] norm_word;
    logic              issue;
    logic              term;
    logic              unused_m2_read;

    assign unused_m2_read = ^m2ReadVal;

    for (genvar i = 0; i < NumBytes; i++) begin : g_norm
        byte_normalize u_byte_normalize (
            .data_i (m1ReadVal[8*i +: 8]),
            .data_o (norm_word[8*i +: 8])
        );
    end

    // Next-state logic for the read pointer, stage-1 tag and write register.
    always_comb begin
        issue   = (state_q == StRun) && !halt_q;
        term    = v1_q && ((m1ReadVal == '0) || (a1_q == LastAddr));

        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        halt_d   = halt_q;
        // The read issued alongside a detected terminator is dropped here.
        v1_d     = issue && !term;
        a1_d     = rd_ptr_q;
        last_d   = term;
        waddr_d  = waddr_q;
        wval_d   = wval_q;
        we_d     = v1_q;

        if (v1_q) begin
            waddr_d = a1_q;
            wval_d  = norm_word;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (term) begin
                    halt_d = 1'b1;
                end else if (issue) begin
                    // Saturate at the top address instead of wrapping to 0.
                    if (rd_ptr_q == LastAddr) begin
                        halt_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
                if (last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset clears everything and drops in-flight data.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            halt_q   <= 1'b0;
            v1_q     <= 1'b0;
            a1_q     <= '0;
            last_q   <= 1'b0;
            waddr_q  <= '0;
            wval_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            halt_q   <= halt_d;
            v1_q     <= v1_d;
            a1_q     <= a1_d;
            last_q   <= last_d;
            waddr_q  <= waddr_d;
            wval_q   <= wval_d;
            we_q     <= we_d;
        end
    end

    assign m1ReadAddr  = rd_ptr_q;
    assign m2ReadAddr  = '0;
    assign m2WriteAddr = waddr_q;
    assign m2WriteVal  = wval_q;
    assign m2WE        = we_q;
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_input_pipeline_unit.sv
// Directed and randomised bench for input_pipeline_unit; m2 is a real SRAM
// instance, m1 is a behavioural registered-read memory owned by the bench.
module tb_input_pipeline_unit;

    logic         clock = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  m1ReadAddr;
    logic [127:0] m1ReadVal;
    logic [15:0]  m2ReadAddr;
    logic [127:0] m2ReadVal;
    logic [15:0]  m2WriteAddr;
    logic [127:0] m2WriteVal;
    logic         m2WE;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [127:0] m1_mem [0:65535];

    always #5 clock = ~clock;

    input_pipeline_unit dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .m1ReadAddr  (m1ReadAddr),
        .m1ReadVal   (m1ReadVal),
        .m2ReadAddr  (m2ReadAddr),
        .m2ReadVal   (m2ReadVal),
        .m2WriteAddr (m2WriteAddr),
        .m2WriteVal  (m2WriteVal),
        .m2WE        (m2WE),
        .done        (done)
    );

    sram_1R1W m2 (
        .clock        (clock),
        .WE           (m2WE),
        .WriteAddress (m2WriteAddr),
        .WriteBus     (m2WriteVal),
        .ReadAddress  (m2ReadAddr),
        .ReadBus      (m2ReadVal)
    );

    // m1: one-cycle registered read.
    always @(posedge clock) m1ReadVal <= m1_mem[m1ReadAddr];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference byte rule applied to every byte of a word.
    function automatic logic [127:0] normalise(input logic [127:0] w);
        logic [127:0] r;
        logic [7:0]   b;
        for (int j = 0; j < 16; j++) begin
            b = w[8*j +: 8];
            if (b >= 8'd65 && b <= 8'd90)                      r[8*j +: 8] = b + 8'd32;
            else if ((b >= 8'd97 && b <= 8'd122) || b == 8'd0) r[8*j +: 8] = b;
            else                                               r[8*j +: 8] = 8'd32;
        end
        return r;
    endfunction

    // Address of the word that ends a run started at 0.
    function automatic int find_last();
        for (int a = 0; a < 65536; a++) begin
            if (m1_mem[a] == '0 || a == 65535) return a;
        end
        return 65535;
    endfunction

    function automatic logic [127:0] rand_text_word();
        logic [127:0] w;
        for (int j = 0; j < 16; j++) begin
            case ($urandom_range(0, 3))
                0:       w[8*j +: 8] = 8'(65 + $urandom_range(0, 25));
                1:       w[8*j +: 8] = 8'(97 + $urandom_range(0, 25));
                2:       w[8*j +: 8] = 8'($urandom_range(32, 64));
                default: w[8*j +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        w[127:120] = 8'(65 + $urandom_range(0, 25));
        return w;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
    endtask

    // Start a run from IDLE and check every cycle against the expected schedule.
    task automatic run_check(input string tag, input bit hold_start);
        int n;
        int bad_we = 0, bad_wr = 0, bad_done = 0, bad_mem = 0, we_total = 0, beyond = 0;
        int wr_cnt [int];
        bit exp_we;
        n = find_last();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= n + 8; k++) begin
            @(negedge clock);
            if (!hold_start && k == 3) start = 1'b0;
            if (k == n + 5) start = 1'b1;
            exp_we = (k >= 2 && k <= n + 2);
            if (m2WE !== exp_we) bad_we++;
            if (m2WE === 1'b1) begin
                we_total++;
                wr_cnt[int'(m2WriteAddr)] = wr_cnt[int'(m2WriteAddr)] + 1;
                if (int'(m2WriteAddr) > n) beyond++;
                if (exp_we && (int'(m2WriteAddr) != k - 2 ||
                               m2WriteVal !== normalise(m1_mem[k-2]))) bad_wr++;
            end
            if (done !== (k >= n + 3)) bad_done++;
        end
        for (int a = 0; a <= n; a++) begin
            if (m2.Register[a] !== normalise(m1_mem[a])) bad_mem++;
        end
        check({tag, "_we_window"}, 128'(bad_we), 128'd0);
        check({tag, "_we_count"}, 128'(we_total), 128'(n + 1));
        check({tag, "_write_data"}, 128'(bad_wr), 128'd0);
        check({tag, "_past_term"}, 128'(beyond), 128'd0);
        check({tag, "_done_timing"}, 128'(bad_done), 128'd0);
        check({tag, "_m2_contents"}, 128'(bad_mem), 128'd0);
        check({tag, "_rd_freeze"}, 128'(m1ReadAddr), 128'((n == 65535) ? 65535 : n + 1));
        if (n < 65535) check({tag, "_next_unwritten"}, 128'(wr_cnt.exists(n + 1)), 128'd0);
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] t;
        int           bad_idle_we, bad_idle_done, bad_idle_ptr;

        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 65536; a++) m1_mem[a] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_m1ReadAddr", 128'(m1ReadAddr), 128'd0);
        check("rst_m2ReadAddr", 128'(m2ReadAddr), 128'd0);
        check("rst_m2WriteAddr", 128'(m2WriteAddr), 128'd0);
        check("rst_m2WriteVal", m2WriteVal, 128'd0);
        check("rst_m2WE", 128'(m2WE), 128'd0);
        check("rst_done", 128'(done), 128'd0);

        // Idle with start low: nothing must move.
        rst = 1'b0;
        bad_idle_we = 0; bad_idle_done = 0; bad_idle_ptr = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (m2WE !== 1'b0) bad_idle_we++;
            if (done !== 1'b0) bad_idle_done++;
            if (m1ReadAddr !== 16'd0) bad_idle_ptr++;
        end
        check("idle_m2WE", 128'(bad_idle_we), 128'd0);
        check("idle_done", 128'(bad_idle_done), 128'd0);
        check("idle_rd_ptr", 128'(bad_idle_ptr), 128'd0);

        // Hello-world word followed by a terminator.
        m1_mem[0] = 128'h48656C6C6F2C20576F726C6421000000;
        m1_mem[1] = '0;
        m1_mem[2] = 128'h41424344414243444142434441424344;
        run_check("hello", 1'b0);
        t = m2.Register[0];
        check("hello_m2_0", t, 128'h68656C6C6F2020776F726C6420000000);
        check("hello_m2ReadVal", m2ReadVal, 128'h68656C6C6F2020776F726C6420000000);

        // Ten words of mixed text plus terminator at 10.
        do_reset();
        for (int a = 0; a < 10; a++) m1_mem[a] = rand_text_word();
        m1_mem[10] = '0;
        m1_mem[11] = rand_text_word();
        run_check("text", 1'b0);

        // Every byte value 0x00..0xFF, MSB first, then a zero word.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) m1_mem[i][8*(15-j) +: 8] = 8'(16 * i + j);
        end
        m1_mem[16] = '0;
        run_check("sweep", 1'b1);
        t = m2.Register[4];
        check("sweep_0x41", 128'(t[8*14 +: 8]), 128'h61);
        t = m2.Register[7];
        check("sweep_0x7B", 128'(t[8*4 +: 8]), 128'h20);
        t = m2.Register[0];
        check("sweep_0x00", 128'(t[8*15 +: 8]), 128'h00);
        t = m2.Register[6];
        check("sweep_0x61", 128'(t[8*14 +: 8]), 128'h61);

        // Reset pulsed in cycle 5 of a 20-word run, then a clean restart.
        do_reset();
        for (int a = 0; a < 20; a++) m1_mem[a] = rand_text_word();
        m1_mem[20] = '0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 5; k++) @(negedge clock);
        check("midrst_busy", 128'(m2WE), 128'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_m1ReadAddr", 128'(m1ReadAddr), 128'd0);
        check("midrst_m2ReadAddr", 128'(m2ReadAddr), 128'd0);
        check("midrst_m2WriteAddr", 128'(m2WriteAddr), 128'd0);
        check("midrst_m2WriteVal", m2WriteVal, 128'd0);
        check("midrst_m2WE", 128'(m2WE), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        for (int a = 0; a < 20; a++) m1_mem[a] = rand_text_word();
        run_check("restart", 1'b0);

        // No terminator anywhere: run must stop at the top address.
        do_reset();
        for (int a = 0; a < 65536; a++) begin
            m1_mem[a] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        end
        run_check("full", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
